// File: rtl/xor_tree_acc.sv
// xor_tree_acc: N-lane XOR reduction with optional multi-beat frame accumulation.
// Mode 0 produces one result per accepted beat. Mode 1 XOR-accumulates beats
// until last_i or MAXLEN beats. A single registered output slot uses a
// valid/ready handshake and can refill in the cycle it drains, so throughput
// stays at one beat per cycle. parity_o gives the sign/parity bit of the result
// to downstream fixed-point stages.
module xor_tree_acc #(
    parameter int W      = 32,
    parameter int N      = 3,
    parameter int MAXLEN = 16,
    localparam int CW    = $clog2(MAXLEN + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode_i,
    input  logic            valid_i,
    input  logic            last_i,
    input  logic [N*W-1:0]  data_i,
    output logic            ready_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [W-1:0]    data_o,
    output logic            parity_o,
    output logic [CW-1:0]   count_o,
    output logic            ovf_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // XOR of all lanes of one beat.
    function automatic logic [W-1:0] f_lane_xor(input logic [N*W-1:0] lanes);
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) begin
            v = v ^ lanes[k*W +: W];
        end
        return v;
    endfunction

    // Even-parity bit (XOR reduction) of a result word.
    function automatic logic f_parity(input logic [W-1:0] v);
        return ^v;
    endfunction

    // Registered state.
    state_t         r_state;
    logic           r_mode;
    logic [W-1:0]   r_acc;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_data;
    logic [CW-1:0]  r_count;
    logic           r_ovf;

    // Combinational helpers and next-state values.
    logic [W-1:0]   w_x;
    logic           w_accept;
    logic           w_start;
    logic           w_first_close;
    logic [CW-1:0]  w_cnt_inc;
    logic           w_at_max;
    state_t         w_state_nx;
    logic           w_mode_nx;
    logic [W-1:0]   w_acc_nx;
    logic [CW-1:0]  w_cnt_nx;
    logic [W-1:0]   w_data_nx;
    logic [CW-1:0]  w_count_nx;
    logic           w_ovf_nx;

    // The output slot may take a new beat whenever it is empty or draining now.
    assign ready_o   = (r_state != S_OUT) || ready_i;
    assign w_accept  = valid_i && ready_o;
    assign w_x       = f_lane_xor(data_i);
    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_at_max  = (w_cnt_inc == CW'(MAXLEN));

    // A beat accepted in IDLE, or in OUT while the result drains, opens a new frame.
    assign w_start   = w_accept && ((r_state == S_IDLE) || (r_state == S_OUT));

    // Decide whether the first beat of a frame also closes it (mode 0 or a one-beat frame).
    always_comb begin
        w_first_close = 1'b0;
        if (!mode_i || last_i) begin
            w_first_close = 1'b1;
        end else begin
            w_first_close = 1'b0;
        end
    end

    // Next-state and datapath selection for frame start, accumulation and output hold.
    always_comb begin
        w_state_nx = r_state;
        w_mode_nx  = r_mode;
        w_acc_nx   = r_acc;
        w_cnt_nx   = r_cnt;
        w_data_nx  = r_data;
        w_count_nx = r_count;
        w_ovf_nx   = r_ovf;
        if (w_start) begin
            w_mode_nx = mode_i;
            if (w_first_close) begin
                w_data_nx  = w_x;
                w_count_nx = CW'(1);
                w_ovf_nx   = 1'b0;
                w_acc_nx   = '0;
                w_cnt_nx   = '0;
                w_state_nx = S_OUT;
            end else begin
                w_acc_nx   = w_x;
                w_cnt_nx   = CW'(1);
                w_state_nx = S_ACC;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nx = S_IDLE;
                end
                S_ACC: begin
                    if (w_accept) begin
                        // r_mode is always 1 here; treating 0 as a close keeps a
                        // corrupted mode bit from trapping the block in ACC.
                        if (last_i || w_at_max || !r_mode) begin
                            w_data_nx  = r_acc ^ w_x;
                            w_count_nx = w_cnt_inc;
                            w_ovf_nx   = w_at_max && !last_i;
                            w_acc_nx   = '0;
                            w_cnt_nx   = '0;
                            w_state_nx = S_OUT;
                        end else begin
                            w_acc_nx   = r_acc ^ w_x;
                            w_cnt_nx   = w_cnt_inc;
                            w_state_nx = S_ACC;
                        end
                    end else begin
                        w_state_nx = S_ACC;
                    end
                end
                S_OUT: begin
                    if (ready_i) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_state_nx = S_OUT;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_acc_nx   = '0;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_mode  <= w_mode_nx;
            r_acc   <= w_acc_nx;
            r_cnt   <= w_cnt_nx;
            r_data  <= w_data_nx;
            r_count <= w_count_nx;
            r_ovf   <= w_ovf_nx;
        end
    end

    assign valid_o  = (r_state == S_OUT);
    assign data_o   = r_data;
    assign parity_o = f_parity(r_data);
    assign count_o  = r_count;
    assign ovf_o    = r_ovf;

endmodule

// File: tb/tb_xor_tree_acc.sv
// Self-checking bench for xor_tree_acc (W=8, N=3, MAXLEN=4): directed steps
// plus a short random run, with a scoreboard of expected results.
module tb_xor_tree_acc;

    localparam int W      = 8;
    localparam int N      = 3;
    localparam int MAXLEN = 4;
    localparam int CW     = $clog2(MAXLEN + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            mode_i;
    logic            valid_i;
    logic            last_i;
    logic [N*W-1:0]  data_i;
    logic            ready_o;
    logic            valid_o;
    logic            ready_i;
    logic [W-1:0]    data_o;
    logic            parity_o;
    logic [CW-1:0]   count_o;
    logic            ovf_o;

    xor_tree_acc #(.W(W), .N(N), .MAXLEN(MAXLEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .mode_i   (mode_i),
        .valid_i  (valid_i),
        .last_i   (last_i),
        .data_i   (data_i),
        .ready_o  (ready_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .data_o   (data_o),
        .parity_o (parity_o),
        .count_o  (count_o),
        .ovf_o    (ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [CW-1:0] c;
        logic          o;
    } exp_t;

    exp_t         sb_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    bit           m_active = 1'b0;
    logic [W-1:0] m_acc    = '0;
    int           m_cnt    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference behaviour for one accepted beat; closed frames go to the scoreboard.
    task automatic model_beat(input logic mode, input logic last, input logic [N*W-1:0] d);
        logic [W-1:0] x;
        exp_t         e;
        int           n;
        x = d[0 +: W] ^ d[W +: W] ^ d[2*W +: W];
        if (!m_active) begin
            if (!mode || last) begin
                e.d = x; e.c = CW'(1); e.o = 1'b0;
                sb_q.push_back(e);
            end else begin
                m_active = 1'b1; m_acc = x; m_cnt = 1;
            end
        end else begin
            n = m_cnt + 1;
            if (last || n == MAXLEN) begin
                e.d = m_acc ^ x; e.c = CW'(n); e.o = (n == MAXLEN) && !last;
                sb_q.push_back(e);
                m_active = 1'b0; m_cnt = 0;
            end else begin
                m_acc = m_acc ^ x; m_cnt = n;
            end
        end
    endtask

    task automatic wait_accept();
        bit got;
        int i;
        got = 1'b0;
        i = 0;
        while (!got && i < 50) begin
            @(negedge clk);
            if (valid_i && ready_o) got = 1'b1;
            i = i + 1;
        end
        chk("accept_within_bound", 32'(got), 32'd1);
        if (got) model_beat(mode_i, last_i, data_i);
    endtask

    task automatic send_beat(input logic mode, input logic last,
                             input logic [W-1:0] l0, input logic [W-1:0] l1, input logic [W-1:0] l2);
        mode_i  = mode;
        last_i  = last;
        data_i  = {l2, l1, l0};
        valid_i = 1'b1;
        wait_accept();
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        mode_i  = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every output handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (rst === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
            chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("res_data",   32'(data_o),   32'(e.d));
                chk("res_count",  32'(count_o),  32'(e.c));
                chk("res_ovf",    32'(ovf_o),    32'(e.o));
                chk("res_parity", 32'(parity_o), 32'(^e.d));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; mode_i = 1'b0; valid_i = 1'b0; last_i = 1'b0;
        ready_i = 1'b1; data_i = '0;
        idle(3);
        // Reset state
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_data",  32'(data_o),  32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_ovf",   32'(ovf_o),   32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        rst = 1'b1;
        idle(1);

        // 1. Per-beat XOR
        send_beat(1'b0, 1'b0, 8'h0F, 8'hF0, 8'h55);
        chk("t1_valid",  32'(valid_o),  32'd1);
        chk("t1_data",   32'(data_o),   32'hAA);
        chk("t1_parity", 32'(parity_o), 32'd0);
        idle(2);

        // 2. Frame accumulate
        send_beat(1'b1, 1'b0, 8'hA5, 8'h00, 8'h00);
        chk("t2_no_valid_b1", 32'(valid_o), 32'd0);
        send_beat(1'b1, 1'b0, 8'hFF, 8'h00, 8'h00);
        chk("t2_no_valid_b2", 32'(valid_o), 32'd0);
        send_beat(1'b1, 1'b1, 8'h01, 8'h02, 8'h04);
        chk("t2_data",   32'(data_o),   32'h5D);
        chk("t2_parity", 32'(parity_o), 32'd1);
        chk("t2_count",  32'(count_o),  32'd3);
        idle(2);

        // 3. Overflow at MAXLEN, then a fresh frame right behind it
        repeat (MAXLEN) send_beat(1'b1, 1'b0, 8'h01, 8'h00, 8'h00);
        chk("t3_data",  32'(data_o),  32'h00);
        chk("t3_count", 32'(count_o), 32'd4);
        chk("t3_ovf",   32'(ovf_o),   32'd1);
        send_beat(1'b1, 1'b1, 8'h33, 8'h00, 8'h00);
        chk("t3b_data",  32'(data_o),  32'h33);
        chk("t3b_count", 32'(count_o), 32'd1);
        chk("t3b_ovf",   32'(ovf_o),   32'd0);
        idle(2);

        // last_i on exactly the MAXLEN-th beat is not an overflow
        send_beat(1'b1, 1'b0, 8'h01, 8'h00, 8'h00);
        send_beat(1'b1, 1'b0, 8'h02, 8'h00, 8'h00);
        send_beat(1'b1, 1'b0, 8'h04, 8'h00, 8'h00);
        send_beat(1'b1, 1'b1, 8'h08, 8'h00, 8'h00);
        chk("lastmax_data", 32'(data_o), 32'h0F);
        chk("lastmax_ovf",  32'(ovf_o),  32'd0);
        idle(2);

        // 4. Backpressure with a beat waiting
        ready_i = 1'b0;
        send_beat(1'b0, 1'b0, 8'h0F, 8'h00, 8'h00);
        mode_i = 1'b0; last_i = 1'b0; data_i = {8'h00, 8'h22, 8'h11}; valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_ready_low", 32'(ready_o), 32'd0);
            chk("t4_valid",     32'(valid_o), 32'd1);
            chk("t4_data_hold", 32'(data_o),  32'h0F);
            chk("t4_cnt_hold",  32'(count_o), 32'd1);
        end
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        wait_accept();
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        chk("t4_next_valid", 32'(valid_o), 32'd1);
        chk("t4_next_data",  32'(data_o),  32'h33);
        idle(2);

        // 5. Reset mid-frame
        send_beat(1'b1, 1'b0, 8'h12, 8'h00, 8'h00);
        send_beat(1'b1, 1'b0, 8'h34, 8'h00, 8'h00);
        chk("t5_no_valid", 32'(valid_o), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_active = 1'b0; m_cnt = 0; m_acc = '0;
        chk("t5_rst_valid", 32'(valid_o), 32'd0);
        chk("t5_rst_count", 32'(count_o), 32'd0);
        send_beat(1'b1, 1'b1, 8'h3C, 8'h00, 8'h00);
        chk("t5_data",  32'(data_o),  32'h3C);
        chk("t5_count", 32'(count_o), 32'd1);
        idle(2);

        // 6. Mode latched on the first beat only
        send_beat(1'b1, 1'b0, 8'h11, 8'h00, 8'h00);
        send_beat(1'b0, 1'b0, 8'h22, 8'h00, 8'h00);
        chk("t6_no_valid", 32'(valid_o), 32'd0);
        send_beat(1'b0, 1'b1, 8'h44, 8'h00, 8'h00);
        chk("t6_data",  32'(data_o),  32'h77);
        chk("t6_count", 32'(count_o), 32'd3);
        idle(2);

        // Random beats back to back
        for (int i = 0; i < 40; i++) begin
            logic [31:0] r;
            r = $urandom();
            send_beat(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                      r[7:0], r[15:8], r[23:16]);
        end
        send_beat(1'b1, 1'b1, 8'h5A, 8'hC3, 8'h0F);
        idle(4);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/xor_tree_acc.md
Name: xor_tree_acc

Overview:
- Parametrised successor to the fixed three-input sign XOR in the linearizer/normalizer path.
- Each beat reduces N lanes of W-bit operands by bitwise XOR.
- Mode 0: one result per beat. Mode 1: results are XOR-accumulated across a multi-beat frame, closed by last_i or by a length limit.
- Registered valid/ready output; sign/parity bit for downstream fixed-point stages.

Parameters:
W, 32, operand/result width in bits (>=1)
N, 3, operands (lanes) per beat (>=2)
MAXLEN, 16, maximum beats per accumulated frame (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
mode_i  input  1  0 = per-beat XOR, 1 = frame accumulate; sampled on first beat of frame
valid_i  input  1  input beat valid
last_i  input  1  final beat of frame (mode 1 only)
data_i  input  N*W  lanes; lane k = data_i[k*W +: W]
ready_o  output  1  block can accept a beat this cycle
valid_o  output  1  result valid
ready_i  input  1  downstream accepts result
data_o  output  W  XOR result
parity_o  output  1  XOR-reduction of data_o (combinational from register)
count_o  output  CW  beats in the result, CW = clog2(MAXLEN+1)
ovf_o  output  1  frame closed by MAXLEN without last_i

Behaviour:
- Reset (rst=0 at clk edge):
  - state=IDLE; valid_o=0; data_o=0; count_o=0; ovf_o=0.
  - Internal accumulator=0; latched mode=0.
  - Reset during ACC or OUT discards the partial frame and the pending result.
- Beat XOR: x = lane0 ^ lane1 ^ ... ^ lane(N-1), purely combinational into the registers.
- Accept: valid_i && ready_o. Output handshake: valid_o && ready_i.
- ready_o = (state != OUT) || ready_i. A new beat may be accepted in the same cycle the held result drains (full throughput).
- valid_o = (state == OUT). data_o, count_o and ovf_o stay stable while valid_o=1 and ready_i=0.
- States:
  - IDLE: on accept, latch mode_i.
    - If mode_i=0, or last_i=1: data_o<=x, count_o<=1, ovf_o<=0 -> OUT.
    - Else: acc<=x, cnt<=1 -> ACC.
  - ACC: on accept, n = cnt+1.
    - If last_i=1 or n==MAXLEN: data_o<=acc^x, count_o<=n, ovf_o<=(n==MAXLEN && !last_i) -> OUT.
    - Else: acc<=acc^x, cnt<=n; stay in ACC.
    - No accept: hold.
  - OUT: if ready_i=1, the result drains.
    - If a beat is accepted in the same cycle, apply the IDLE rules to it (new frame, mode_i re-latched).
    - Otherwise -> IDLE.
    - If ready_i=0: hold; no beat accepted.
- Latency: result registered one cycle after the accepting edge of the closing beat.
- mode_i and last_i are ignored on non-accepted cycles. mode_i changes mid-frame are ignored. last_i is ignored in mode 0.
- last_i on exactly the MAXLEN-th beat: ovf_o=0.
- valid_i=0 for any number of cycles mid-frame: ACC holds acc and cnt indefinitely.
- No arithmetic beyond the counter. cnt never exceeds MAXLEN and does not wrap.

Test Plan:
1. Per-beat XOR:
   - Stimulus: W=8, N=3, mode 0, ready_i=1, lanes 0x0F,0xF0,0x55.
   - Response: next cycle valid_o=1, data_o=0xAA, parity_o=0, count_o=1, ovf_o=0.
2. Frame accumulate:
   - Stimulus: mode 1, beats (A5,00,00), (FF,00,00), (01,02,04) with last_i on beat 3.
   - Response: single result data_o=0x5D, parity_o=1, count_o=3, ovf_o=0; valid_o=0 during beats 1-2.
3. Overflow:
   - Stimulus: MAXLEN=4, mode 1, four beats (01,00,00), no last_i; then one further beat (33,00,00) with last_i.
   - Response: first result data_o=0x00, count_o=4, ovf_o=1. The further beat starts a new frame: data_o=0x33, count_o=1, ovf_o=0.
4. Backpressure:
   - Stimulus: hold ready_i=0 for 5 cycles with the result pending and valid_i=1 throughout; then raise ready_i.
   - Response while held: ready_o=0; data_o and count_o stable; no beat consumed.
   - Response on release: result drains and the waiting beat is accepted in the same cycle; its result follows one cycle later.
5. Reset mid-frame:
   - Stimulus: mode 1, two beats accepted, rst=0 for one cycle, then beat (3C,00,00) with last_i.
   - Response: valid_o=0 and count_o=0 after reset; result data_o=0x3C, count_o=1.
6. Mode latch:
   - Stimulus: start a mode-1 frame, flip mode_i to 0 on beat 2, send last_i on beat 3.
   - Response: one accumulated result with count_o=3; no per-beat results emitted.
